chunk_blur: RTL and testbench

- Consumes the 3x3 pixel chunks produced by the line-buffer stage, one chunk per transfer.
- Produces one Gaussian-smoothed RGB pixel per chunk using kernel [1 2 1; 2 4 2; 1 2 1]/16, applied independently per channel.
- Sits directly downstream of the line buffer and upstream of colour-band classification.
- Fully pipelined with AXI-stream backpressure; throughput 1 pixel/clk.

---
 rtl/pixel_pkg.sv | 39 +++
 rtl/axis_if.sv | 11 +
 rtl/chunk_blur_chan.sv | 57 +++++
 rtl/chunk_blur.sv | 63 ++++++
 tb/tb_chunk_blur.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Pixel/chunk payload types and Gaussian blur constants shared by the
// line-buffer, blur and classification stages.
package pixel_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned BLUR_ROW_W = 10;
  localparam int unsigned BLUR_SUM_W = 12;
  localparam int unsigned BLUR_SHIFT = 4;
  localparam int unsigned BLUR_RND   = 8;

  // Separable kernel: [1 2 1] along a row, then [1 2 1] across rows.
  localparam int unsigned BLUR_K_OUTER = 1;
  localparam int unsigned BLUR_K_INNER = 2;

  typedef logic [PIX_W-1:0] chan_t;

  typedef struct packed {
    chan_t red;
    chan_t grn;
    chan_t blu;
  } pixel_t;

  // chunk[row][col]; row 0 = oldest line, col 0 = oldest column
  typedef pixel_t [2:0][2:0] chunk_t;
  typedef chan_t  [2:0][2:0] chan_chunk_t;

  typedef logic [2:0][BLUR_ROW_W-1:0] blur_row_t;

  function automatic logic [BLUR_SUM_W-1:0] blur_tap(
    input logic [BLUR_SUM_W-1:0] a,
    input logic [BLUR_SUM_W-1:0] b,
    input logic [BLUR_SUM_W-1:0] c
  );
    return a * BLUR_SUM_W'(BLUR_K_OUTER)
         + b * BLUR_SUM_W'(BLUR_K_INNER)
         + c * BLUR_SUM_W'(BLUR_K_OUTER);
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream style handshake bundle with a typed payload.
interface axis_if #(
  parameter type data_t = logic [7:0]
);
  data_t data;
  logic  vld;
  logic  rdy;

  modport master (output data, output vld, input rdy);
  modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/chunk_blur_chan.sv
// One colour channel of the 3x3 Gaussian blur: row taps (S1), column
// tap (S2), round/shift or centre bypass (S3). All stages load on adv_i.
module blur_chan
  import pixel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_i,
  input  chan_chunk_t px_i,
  input  logic        byp_i,
  output chan_t       px_o
);

  blur_row_t             row_q, row_d;
  logic [BLUR_SUM_W-1:0] tot_q, tot_d;
  logic [BLUR_SUM_W-1:0] rnd_c;
  chan_t                 ctr1_q, ctr2_q;
  logic                  byp1_q, byp2_q;
  chan_t                 px_q, px_d;

  always_comb begin
    row_d[0] = BLUR_ROW_W'(blur_tap(BLUR_SUM_W'(px_i[0][0]), BLUR_SUM_W'(px_i[0][1]),
                                    BLUR_SUM_W'(px_i[0][2])));
    row_d[1] = BLUR_ROW_W'(blur_tap(BLUR_SUM_W'(px_i[1][0]), BLUR_SUM_W'(px_i[1][1]),
                                    BLUR_SUM_W'(px_i[1][2])));
    row_d[2] = BLUR_ROW_W'(blur_tap(BLUR_SUM_W'(px_i[2][0]), BLUR_SUM_W'(px_i[2][1]),
                                    BLUR_SUM_W'(px_i[2][2])));
    tot_d    = blur_tap(BLUR_SUM_W'(row_q[0]), BLUR_SUM_W'(row_q[1]), BLUR_SUM_W'(row_q[2]));
    // Total is at most 4080, so the rounded quotient always fits in 8 bits.
    rnd_c    = (tot_q + BLUR_SUM_W'(BLUR_RND)) >> BLUR_SHIFT;
    px_d     = byp2_q ? ctr2_q : PIX_W'(rnd_c);
    assert (rnd_c <= BLUR_SUM_W'(255));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      ctr1_q <= '0;
      byp1_q <= 1'b0;
      tot_q  <= '0;
      ctr2_q <= '0;
      byp2_q <= 1'b0;
      px_q   <= '0;
    end else if (adv_i) begin
      row_q  <= row_d;
      ctr1_q <= px_i[1][1];
      byp1_q <= byp_i;
      tot_q  <= tot_d;
      ctr2_q <= ctr1_q;
      byp2_q <= byp1_q;
      px_q   <= px_d;
    end
  end

  assign px_o = px_q;

endmodule

// File: rtl/chunk_blur.sv
// 3x3 Gaussian blur stage: one chunk in, one smoothed RGB pixel out,
// three-deep pipeline with AXI-stream backpressure.
module chunk_blur
  import pixel_pkg::*;
#(
  parameter bit          BYPASS_EN = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bypass,
  axis_if.slave            axis_i,
  axis_if.master           axis_o,
  output logic [CNT_W-1:0] out_cnt
);

  logic             adv_c;
  logic             acc_c;
  logic             byp_c;
  logic [2:0]       vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  chunk_t           chunk_c;
  chan_chunk_t      red_c, grn_c, blu_c;
  chan_t            red_px, grn_px, blu_px;

  always_comb begin
    adv_c   = ~vld_q[2] | axis_o.rdy;
    acc_c   = axis_i.vld & adv_c & en & ~rst;
    byp_c   = bypass & BYPASS_EN;
    chunk_c = axis_i.data;
    vld_d   = adv_c ? {vld_q[1:0], acc_c} : vld_q;
    cnt_d   = cnt_q + CNT_W'(vld_q[2] & axis_o.rdy);
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign red_c[r][c] = chunk_c[r][c].red;
      assign grn_c[r][c] = chunk_c[r][c].grn;
      assign blu_c[r][c] = chunk_c[r][c].blu;
    end
  end

  blur_chan u_red (.clk(clk), .rst(rst), .adv_i(adv_c), .px_i(red_c), .byp_i(byp_c), .px_o(red_px));
  blur_chan u_grn (.clk(clk), .rst(rst), .adv_i(adv_c), .px_i(grn_c), .byp_i(byp_c), .px_o(grn_px));
  blur_chan u_blu (.clk(clk), .rst(rst), .adv_i(adv_c), .px_i(blu_c), .byp_i(byp_c), .px_o(blu_px));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign axis_i.rdy  = adv_c & en & ~rst;
  assign axis_o.vld  = vld_q[2];
  assign axis_o.data = {red_px, grn_px, blu_px};
  assign out_cnt     = cnt_q;

endmodule

// File: tb/tb_chunk_blur.sv
// Scoreboard bench for chunk_blur; a second instance (no bypass, 4-bit
// counter) runs on the same stimulus to cover bypass tie-off and wrap.
module tb_chunk_blur;
  import pixel_pkg::*;

  typedef struct packed {
    pixel_t px;
    pixel_t px_nb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        bypass = 1'b0;
  logic [31:0] out_cnt;
  logic [3:0]  out_cnt2;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cnt_model = 0;
  bit          rnd_mode = 1'b0;
  exp_t        sb_q[$];

  axis_if #(.data_t(chunk_t)) in_if ();
  axis_if #(.data_t(pixel_t)) out_if ();
  axis_if #(.data_t(chunk_t)) in2_if ();
  axis_if #(.data_t(pixel_t)) out2_if ();

  assign in2_if.data = in_if.data;
  assign in2_if.vld  = in_if.vld;
  assign out2_if.rdy = out_if.rdy;

  chunk_blur #(.BYPASS_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .bypass(bypass),
    .axis_i(in_if), .axis_o(out_if), .out_cnt(out_cnt)
  );

  chunk_blur #(.BYPASS_EN(1'b0), .CNT_W(4)) dut_nb (
    .clk(clk), .rst(rst), .en(en), .bypass(bypass),
    .axis_i(in2_if), .axis_o(out2_if), .out_cnt(out_cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic pixel_t blur_ref(input chunk_t c);
    int k[3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
    int sr = 0, sg = 0, sb = 0;
    pixel_t p;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++) begin
        sr += k[r][j] * int'(c[r][j].red);
        sg += k[r][j] * int'(c[r][j].grn);
        sb += k[r][j] * int'(c[r][j].blu);
      end
    p.red = 8'((sr + 8) / 16);
    p.grn = 8'((sg + 8) / 16);
    p.blu = 8'((sb + 8) / 16);
    return p;
  endfunction

  function automatic chunk_t fill(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    chunk_t c;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) c[i][j] = '{red: r, grn: g, blu: b};
    return c;
  endfunction

  function automatic chunk_t rnd_chunk();
    chunk_t c;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) c[i][j] = pixel_t'(24'($urandom));
    return c;
  endfunction

  // Monitor: counter model, output scoreboard pops, accept-time pushes.
  always @(negedge clk) begin
    chunk_t ci;
    exp_t   e;
    if (rst) begin
      cnt_model = 0;
    end else begin
      check("out_cnt", out_cnt, cnt_model);
      check("out_cnt_w4", 32'(out_cnt2), cnt_model & 32'hF);
      if (out_if.vld && out_if.rdy) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("pix", 32'(out_if.data), 32'(e.px));
          check("pix_nb", 32'(out2_if.data), 32'(e.px_nb));
        end
        cnt_model++;
      end
      if (in_if.vld && in_if.rdy) begin
        ci = in_if.data;
        e.px    = bypass ? ci[1][1] : blur_ref(ci);
        e.px_nb = blur_ref(ci);
        sb_q.push_back(e);
      end
    end
  end

  task automatic send(input chunk_t c, input logic byp, output int acc_cyc);
    bit acc = 1'b0;
    int n = 0;
    acc_cyc = 0;
    in_if.data = c;
    in_if.vld  = 1'b1;
    bypass     = byp;
    while (!acc && n < 100) begin
      if (rnd_mode) begin
        out_if.rdy = ($urandom_range(0, 3) != 0);
        en         = ($urandom_range(0, 7) != 0);
      end
      @(negedge clk);
      acc     = in_if.rdy;
      acc_cyc = cyc;
      if (!en) check("rdy_en_low", 32'(in_if.rdy), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check("send_accepted", 32'(acc), 32'd1);
    in_if.vld = 1'b0;
  endtask

  task automatic wait_out(input int acc_cyc);
    int n = 0;
    while (!out_if.vld && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(cyc - acc_cyc), 32'd3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int     acc;
    int     t0;
    pixel_t hold;
    chunk_t c;

    in_if.vld  = 1'b0;
    in_if.data = '0;
    out_if.rdy = 1'b1;
    en         = 1'b1;
    rst        = 1'b1;
    idle(3);
    check("rst_out_vld", 32'(out_if.vld), 32'd0);
    check("rst_out_data", 32'(out_if.data), 32'd0);
    check("rst_out_cnt", out_cnt, 32'd0);
    check("rst_in_rdy", 32'(in_if.rdy), 32'd0);
    rst = 1'b0;
    idle(1);

    send(fill(8'd100, 8'd100, 8'd100), 1'b0, acc);
    wait_out(acc);
    check("uniform_100", 32'(out_if.data), 32'h646464);
    idle(3);
    check("cnt_one", out_cnt, 32'd1);

    c = fill(8'd0, 8'd0, 8'd0);
    c[1][1].red = 8'd255;
    send(c, 1'b0, acc);
    wait_out(acc);
    check("centre_255", 32'(out_if.data), 32'h400000);
    c = fill(8'd0, 8'd0, 8'd0);
    c[0][0].red = 8'd16;
    send(c, 1'b0, acc);
    send(fill(8'd255, 8'd255, 8'd255), 1'b0, acc);
    idle(5);

    // bypass: centre passes through, bypass-disabled instance filters
    c = rnd_chunk();
    c[1][1] = '{red: 8'd12, grn: 8'd34, blu: 8'd56};
    send(c, 1'b1, acc);
    wait_out(acc);
    check("bypass_centre", 32'(out_if.data), 32'h0C2238);
    idle(4);

    t0 = cyc;
    for (int i = 0; i < 1000; i++) send(rnd_chunk(), 1'($urandom_range(0, 1)), acc);
    check("burst_cycles", 32'(cyc - t0), 32'd1000);
    idle(5);

    // backpressure with a full pipeline
    out_if.rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd_chunk(), 1'b0, acc);
    hold = out_if.data;
    in_if.data = rnd_chunk();
    in_if.vld  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_rdy", 32'(in_if.rdy), 32'd0);
      check("bp_out_vld", 32'(out_if.vld), 32'd1);
      check("bp_data_stable", 32'(out_if.data), 32'(hold));
    end
    @(posedge clk); #1;
    in_if.vld  = 1'b0;
    out_if.rdy = 1'b1;
    idle(5);

    // en low mid-stream: in-flight pixels still drain
    send(rnd_chunk(), 1'b0, acc);
    send(rnd_chunk(), 1'b0, acc);
    en = 1'b0;
    in_if.data = rnd_chunk();
    in_if.vld  = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("en_low_rdy", 32'(in_if.rdy), 32'd0);
    end
    @(posedge clk); #1;
    in_if.vld = 1'b0;
    en = 1'b1;
    check("en_low_drained", 32'(sb_q.size()), 32'd0);

    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) send(rnd_chunk(), 1'($urandom_range(0, 1)), acc);
    rnd_mode   = 1'b0;
    out_if.rdy = 1'b1;
    en         = 1'b1;
    idle(6);

    // reset with pixels in flight
    out_if.rdy = 1'b0;
    send(rnd_chunk(), 1'b0, acc);
    send(rnd_chunk(), 1'b0, acc);
    idle(1);
    @(negedge clk); #2;
    rst = 1'b1;
    sb_q.delete();
    cnt_model = 0;
    #1;
    check("mid_rst_out_vld", 32'(out_if.vld), 32'd0);
    check("mid_rst_out_cnt", out_cnt, 32'd0);
    check("mid_rst_in_rdy", 32'(in_if.rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_if.rdy = 1'b1;
    send(fill(8'd7, 8'd77, 8'd177), 1'b0, acc);
    wait_out(acc);
    check("post_rst_pix", 32'(out_if.data), 32'h074DB1);
    idle(5);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
